// File: rtl/ctrl_ula_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_ula_pkg
// Shared definitions for the execute-stage ALU controller: default sizing,
// opcode constants, instruction field positions, FSM state encoding and small
// opcode classification helpers. The ALU instance takes its op codes from the
// same constants, so both sides always agree on the encoding.
// ----------------------------------------------------------------------------
package ctrl_ula_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int NREG_DEF        = 4;
    localparam int EXEC_CYCLES_DEF = 2;

    // Register address fields in the instruction are fixed at 2 bits.
    localparam int REG_AW = 2;

    // Opcode constants; 8..F are illegal.
    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_AND = 4'h3;
    localparam logic [3:0] OPC_OR  = 4'h4;
    localparam logic [3:0] OPC_NOT = 4'h5;
    localparam logic [3:0] OPC_XOR = 4'h6;
    localparam logic [3:0] OPC_LDI = 4'h7;

    // Instruction field positions (LSB of each field).
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_LSB  = 8;
    localparam int RT_LSB  = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    // Opcodes that go through the ALU and therefore need the EXEC state.
    function automatic logic isAluOp(input logic [3:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_XOR);
    endfunction

    // Anything with the top bit set is outside the defined opcode space.
    function automatic logic isIllegal(input logic [3:0] opc);
        return opc[3];
    endfunction

endpackage

// File: rtl/ctrl_ula_banco_reg.sv
// ----------------------------------------------------------------------------
// ctrl_ula_banco_reg
// NREG x DATA_W register bank for the ALU controller. Two asynchronous read
// ports feed the ALU operands, a third asynchronous port serves debug reads,
// and a single synchronous write port handles write-back. R0 is an ordinary
// writable register.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low clear of all registers
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   raddrA_i   read port A address   -> rdataA_o
//   raddrB_i   read port B address   -> rdataB_o
//   dbgSel_i   debug read address    -> dbgData_o
// ----------------------------------------------------------------------------
module ctrl_ula_banco_reg
    import ctrl_ula_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddrA_i,
    output logic [DATA_W-1:0] rdataA_o,
    input  logic [REG_AW-1:0] raddrB_i,
    output logic [DATA_W-1:0] rdataB_o,
    input  logic [REG_AW-1:0] dbgSel_i,
    output logic [DATA_W-1:0] dbgData_o
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdataA_o  = regs_q[raddrA_i];
    assign rdataB_o  = regs_q[raddrB_i];
    assign dbgData_o = regs_q[dbgSel_i];

endmodule

// File: rtl/ctrl_ula.sv
// ----------------------------------------------------------------------------
// ctrl_ula
// Execute-stage controller for the 8-bit ALU. Accepts one 16-bit instruction
// per handshake, reads operands from the internal register bank, presents
// a/b/op to the ALU for EXEC_CYCLES cycles, captures the result, writes it
// back and updates the sticky carry/sign flags.
// Ports:
//   clk, rst (async active-low)
//   instr_valid/instr/instr_ready   upstream instruction handshake
//   alu_a/alu_b/alu_op              ALU operands and op code (op 0 outside EXEC)
//   alu_out/alu_carry/alu_sinal     ALU result and status
//   result, flag_carry, flag_sinal  last write-back value and sticky flags
//   done, illegal                   one-cycle completion / rejection pulses
//   dbg_sel/dbg_data                combinational debug register read
// ----------------------------------------------------------------------------
module ctrl_ula
    import ctrl_ula_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NREG        = NREG_DEF,
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    input  logic              alu_sinal,
    output logic [DATA_W-1:0] result,
    output logic              flag_carry,
    output logic              flag_sinal,
    output logic              done,
    output logic              illegal,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int CW = $clog2(EXEC_CYCLES + 1);

    state_e            state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] aluA_q, aluB_q, aluRes_q, result_q;
    logic              aluCarry_q, aluSinal_q;
    logic              flagCarry_q, flagSinal_q;
    logic              done_q, illegal_q, illegalPend_q;
    logic [CW-1:0]     cnt_q;

    logic [3:0]        opc;
    logic [REG_AW-1:0] rd, rs, rt;
    logic [7:0]        imm;
    logic [DATA_W-1:0] rdA, rdB;
    logic              accept;
    logic              wbWe;
    logic [DATA_W-1:0] wbData;

    assign opc    = instr_q[OPC_LSB +: 4];
    assign rd     = instr_q[RD_LSB +: REG_AW];
    assign rs     = instr_q[RS_LSB +: REG_AW];
    assign rt     = instr_q[RT_LSB +: REG_AW];
    assign imm    = instr_q[7:0];
    assign accept = instr_valid && (state_q == ST_IDLE);

    ctrl_ula_banco_reg #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) uBanco (
        .clk_i     (clk),
        .rst_ni    (rst),
        .we_i      (wbWe),
        .waddr_i   (rd),
        .wdata_i   (wbData),
        .raddrA_i  (rs),
        .rdataA_o  (rdA),
        .raddrB_i  (rt),
        .rdataB_o  (rdB),
        .dbgSel_i  (dbg_sel),
        .dbgData_o (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: illegal opcodes bail straight back to IDLE from
    // DECODE, ALU ops spend EXEC_CYCLES in EXEC, NOP/LDI skip EXEC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
            ST_DECODE: begin
                if (isIllegal(opc))    state_d = ST_IDLE;
                else if (isAluOp(opc)) state_d = ST_EXEC;
                else                   state_d = ST_WB;
            end
            ST_EXEC:   if (cnt_q == CW'(EXEC_CYCLES - 1)) state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshake, ALU op qualification and write-back selection.
    // Illegal opcodes never reach WB, so only NOP suppresses the write.
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        alu_op      = (state_q == ST_EXEC) ? opc : 4'h0;
        wbWe        = (state_q == ST_WB) && (opc != OPC_NOP);
        wbData      = (opc == OPC_LDI) ? DATA_W'(imm) : aluRes_q;
    end

    // Datapath registers. Operands are latched on leaving DECODE so that rd
    // may alias rs/rt. The ALU result is sampled every EXEC cycle, so the
    // value kept is the one from the last cycle, after the clocked subtract
    // path has settled. The illegal pulse is delayed one cycle so that it
    // appears with the same accept-to-pulse latency as a NOP's done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q       <= '0;
            aluA_q        <= '0;
            aluB_q        <= '0;
            aluRes_q      <= '0;
            aluCarry_q    <= 1'b0;
            aluSinal_q    <= 1'b0;
            result_q      <= '0;
            flagCarry_q   <= 1'b0;
            flagSinal_q   <= 1'b0;
            done_q        <= 1'b0;
            illegalPend_q <= 1'b0;
            illegal_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            done_q        <= (state_q == ST_WB);
            illegalPend_q <= (state_q == ST_DECODE) && isIllegal(opc);
            illegal_q     <= illegalPend_q;
            if (accept) begin
                instr_q <= instr;
            end
            if (state_q == ST_DECODE) begin
                aluA_q <= rdA;
                aluB_q <= rdB;
                cnt_q  <= '0;
            end
            if (state_q == ST_EXEC) begin
                cnt_q      <= cnt_q + CW'(1);
                aluRes_q   <= alu_out;
                aluCarry_q <= alu_carry;
                aluSinal_q <= alu_sinal;
            end
            if (wbWe) begin
                result_q <= wbData;
                if (opc == OPC_ADD) flagCarry_q <= aluCarry_q;
                if (opc == OPC_SUB) flagSinal_q <= aluSinal_q;
            end
        end
    end

    assign alu_a      = aluA_q;
    assign alu_b      = aluB_q;
    assign result     = result_q;
    assign flag_carry = flagCarry_q;
    assign flag_sinal = flagSinal_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

endmodule
